bcd_window_scroller: RTL and testbench

- Parametrised successor to the fixed 5-digit/3-digit button control unit.
- Shows a WIN_DIGITS-wide window of an NUM_DIGITS-digit packed BCD value on the seven-segment display path.
- Left and right push-buttons move the window one digit at a time; each button is synchronised, debounced and edge-detected inside the block.
- Also drives "more digits off-screen" indicators and the current window offset.

---
 rtl/bcd_window_scroller.sv | 175 +++++++++++++++++
 tb/tb_bcd_window_scroller.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bcd_window_scroller.sv
// rtl/bcd_window_scroller.sv - scrolling WIN_DIGITS window over a packed BCD word, button driven
// SCROLL_WRAP_EN: window offset wraps at both ends instead of saturating.

module bcd_window_scroller_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} db_state_t;

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync;
    logic             s_btn;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;

    assign s_btn = sync[1];

    // The sample that brings cnt to DEBOUNCE_CYCLES is the one that commits the transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= 2'b00;
            state <= IDLE;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_btn) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!s_btn) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= HELD;
                        cnt   <= cnt + CNT_ONE;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!s_btn) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (s_btn) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= cnt + CNT_ONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

module bcd_window_scroller #(
    parameter int NUM_DIGITS      = 5,
    parameter int WIN_DIGITS      = 3,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int POS_W           = (NUM_DIGITS - WIN_DIGITS > 0) ?
                                    $clog2(NUM_DIGITS - WIN_DIGITS + 1) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd,
    input  logic                    BTNL,
    input  logic                    BTNR,
    output logic [4*WIN_DIGITS-1:0] window_digits,
    output logic [POS_W-1:0]        window_pos,
    output logic                    more_left,
    output logic                    more_right
);
    localparam int MAX_POS = NUM_DIGITS - WIN_DIGITS;
    localparam logic [POS_W-1:0] MAX_P   = POS_W'(MAX_POS);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    logic                    press_l;
    logic                    press_r;
    logic [POS_W-1:0]        pos_next;
    logic                    more_left_next;
    logic                    more_right_next;
    logic [4*NUM_DIGITS-1:0] shifted;

    bcd_window_scroller_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk   (clk),
        .rst   (rst),
        .raw   (BTNL),
        .press (press_l)
    );

    bcd_window_scroller_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk   (clk),
        .rst   (rst),
        .raw   (BTNR),
        .press (press_r)
    );

    // Simultaneous left and right pulses cancel; both are consumed.
    always_comb begin
        pos_next = window_pos;
        if (MAX_POS > 0) begin
            if (press_l && !press_r) begin
                if (window_pos == MAX_P) begin
`ifdef SCROLL_WRAP_EN
                    pos_next = '0;
`else
                    pos_next = MAX_P;
`endif
                end else begin
                    pos_next = window_pos + POS_ONE;
                end
            end else if (press_r && !press_l) begin
                if (window_pos == '0) begin
`ifdef SCROLL_WRAP_EN
                    pos_next = MAX_P;
`else
                    pos_next = '0;
`endif
                end else begin
                    pos_next = window_pos - POS_ONE;
                end
            end
        end
    end

    always_comb begin
`ifdef SCROLL_WRAP_EN
        more_left_next  = (MAX_POS > 0);
        more_right_next = (MAX_POS > 0);
`else
        more_left_next  = (pos_next != MAX_P);
        more_right_next = (pos_next != '0);
`endif
    end

    assign shifted = bcd >> {window_pos, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_pos    <= '0;
            window_digits <= '0;
            more_left     <= (MAX_POS > 0);
            more_right    <= 1'b0;
        end else begin
            window_pos    <= pos_next;
            window_digits <= shifted[4*WIN_DIGITS-1:0];
            more_left     <= more_left_next;
            more_right    <= more_right_next;
        end
    end
endmodule

// File: tb/tb_bcd_window_scroller.sv
// tb/tb_bcd_window_scroller.sv - directed bench for bcd_window_scroller (5 digits, 3 shown, debounce 4)
// SCROLL_WRAP_EN selects the wrapping expectations.

module tb_bcd_window_scroller;
`ifdef SCROLL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [19:0] bcd;
    logic        BTNL;
    logic        BTNR;
    logic [11:0] window_digits;
    logic [1:0]  window_pos;
    logic        more_left;
    logic        more_right;

    int n_checks;
    int n_errors;

    bcd_window_scroller #(
        .NUM_DIGITS      (5),
        .WIN_DIGITS      (3),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bcd           (bcd),
        .BTNL          (BTNL),
        .BTNR          (BTNR),
        .window_digits (window_digits),
        .window_pos    (window_pos),
        .more_left     (more_left),
        .more_right    (more_right)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raw edge driven just after an edge: pulse after 6 edges, offset moves on the 7th.
    task automatic press(input string tag, input logic l, input logic r,
                         input logic [1:0] pos_before, input logic [1:0] pos_after,
                         input logic [11:0] digits_after);
        BTNL = l;
        BTNR = r;
        cycles(6);
        check({tag, "_pre"}, 32'(window_pos), 32'(pos_before));
        cycles(1);
        check({tag, "_pos"}, 32'(window_pos), 32'(pos_after));
        cycles(1);
        check({tag, "_dig"}, 32'(window_digits), 32'(digits_after));
        cycles(2);
        BTNL = 1'b0;
        BTNR = 1'b0;
        cycles(10);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst  = 1'b1;
        bcd  = 20'h12345;
        BTNL = 1'b0;
        BTNR = 1'b0;
        cycles(3);
        check("rst_pos", 32'(window_pos), 32'd0);
        check("rst_dig", 32'(window_digits), 32'h0);
        check("rst_ml", 32'(more_left), 32'd1);
        check("rst_mr", 32'(more_right), 32'd0);
        rst = 1'b0;
        cycles(1);
        check("idle_dig", 32'(window_digits), 32'h345);
        cycles(4);
        check("idle_pos", 32'(window_pos), 32'd0);

        press("l1", 1'b1, 1'b0, 2'd0, 2'd1, 12'h234);
        press("l2", 1'b1, 1'b0, 2'd1, 2'd2, 12'h123);
        check("l2_ml", 32'(more_left), WRAP ? 32'd1 : 32'd0);
        check("l2_mr", 32'(more_right), 32'd1);
        press("l3", 1'b1, 1'b0, 2'd2, WRAP ? 2'd0 : 2'd2, WRAP ? 12'h345 : 12'h123);

        // Bounce: 20 cycles of toggling, then a clean hold.
        for (int i = 0; i < 20; i++) begin
            BTNR = (i % 2 == 0);
            cycles(1);
        end
        check("bnc_hold", 32'(window_pos), WRAP ? 32'd0 : 32'd2);
        press("bnc", 1'b0, 1'b1, WRAP ? 2'd0 : 2'd2, WRAP ? 2'd2 : 2'd1,
              WRAP ? 12'h123 : 12'h234);
        check("bnc_mr", 32'(more_right), 32'd1);

        press("both", 1'b1, 1'b1, WRAP ? 2'd2 : 2'd1, WRAP ? 2'd2 : 2'd1,
              WRAP ? 12'h123 : 12'h234);
        check("both_rel", 32'(window_pos), WRAP ? 32'd2 : 32'd1);

        // Reset while the left debouncer is mid-count.
        BTNL = 1'b1;
        cycles(3);
        rst = 1'b1;
        #1;
        check("mid_rst_pos", 32'(window_pos), 32'd0);
        check("mid_rst_mr", 32'(more_right), 32'd0);
        cycles(2);
        rst = 1'b0;
        press("after_rst", 1'b1, 1'b0, 2'd0, 2'd1, 12'h234);

        press("r1", 1'b0, 1'b1, 2'd1, 2'd0, 12'h345);
        press("r2", 1'b0, 1'b1, 2'd0, WRAP ? 2'd2 : 2'd0, WRAP ? 12'h123 : 12'h345);
        check("r2_ml", 32'(more_left), 32'd1);
        check("r2_mr", 32'(more_right), WRAP ? 32'd1 : 32'd0);

        // Non-decimal nibbles pass through with one cycle of latency.
        bcd = 20'hABCDE;
        #1;
        check("hex_old", 32'(window_digits), WRAP ? 32'h123 : 32'h345);
        cycles(1);
        check("hex_new", 32'(window_digits), WRAP ? 32'hABC : 32'hCDE);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
